activation_unit: RTL and testbench

Pipelined activation stage that sits directly downstream of `vector_multiplier`. It accepts one signed Q8.8 neuron pre-activation per handshake and applies the selected function: ReLU, PLAN piecewise-linear sigmoid, or identity. It emits the result with a valid/ready handshake to the next layer's input buffer. The block has a fixed 3-cycle latency and supports full backpressure.

---
 rtl/nn_pkg.sv | 36 +++
 rtl/plan_sigmoid_core.sv | 24 ++
 rtl/activation_unit.sv | 127 ++++++++++++
 tb/tb_activation_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared neural-network datapath types and Q8.8 constants.
package nn_pkg;

  typedef enum logic [1:0] {
    ACT_RELU    = 2'd0,
    ACT_SIGMOID = 2'd1,
    ACT_IDENT   = 2'd2,
    ACT_RSVD    = 2'd3
  } act_sel_e;

  // PLAN segment index, ordered from the saturated tail down to the origin.
  typedef enum logic [1:0] {
    SEG_SAT = 2'd0,
    SEG_HI  = 2'd1,
    SEG_MID = 2'd2,
    SEG_LO  = 2'd3
  } seg_e;

  localparam logic [15:0] Q_ONE   = 16'h0100;
  localparam logic [15:0] Q_HALF  = 16'h0080;

  // PLAN breakpoints (5.0 and 2.375) and segment offsets.
  localparam logic [15:0] BP_SAT  = 16'h0500;
  localparam logic [15:0] BP_HI   = 16'h0260;
  localparam logic [15:0] OFF_HI  = 16'h00D8;
  localparam logic [15:0] OFF_MID = 16'h00A0;

  // Pick the PLAN segment for a non-negative magnitude.
  function automatic seg_e plan_seg(input logic [15:0] a);
    if (a >= BP_SAT)     return SEG_SAT;
    else if (a >= BP_HI) return SEG_HI;
    else if (a >= Q_ONE) return SEG_MID;
    else                 return SEG_LO;
  endfunction

endpackage

// File: rtl/plan_sigmoid_core.sv
// PLAN sigmoid shift+add on the magnitude for an already-chosen segment.
// Output is the positive-half sigmoid value in 0x0080..0x0100.
module plan_sigmoid_core
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] mag_i,
  input  seg_e                  seg_i,
  output logic [DATA_WIDTH-1:0] y_o
);

  // Segment-dependent slope (as a shift) plus intercept.
  always_comb begin
    y_o = DATA_WIDTH'(Q_HALF);
    case (seg_i)
      SEG_SAT: y_o = DATA_WIDTH'(Q_ONE);
      SEG_HI:  y_o = (mag_i >> 5) + DATA_WIDTH'(OFF_HI);
      SEG_MID: y_o = (mag_i >> 3) + DATA_WIDTH'(OFF_MID);
      default: y_o = (mag_i >> 2) + DATA_WIDTH'(Q_HALF);
    endcase
  end

endmodule

// File: rtl/activation_unit.sv
// Three-stage activation pipeline (ReLU / PLAN sigmoid / identity) with a
// valid/ready handshake and full backpressure. The whole pipe freezes when
// the output word is valid but not taken.
module activation_unit
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            act_sel_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in
);

  localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1) << FRAC_BITS;
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // |x| with the most negative code saturated to the largest positive code.
  function automatic logic [DATA_WIDTH-1:0] sat_abs(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH-1:0] negx;
    negx = -x;
    if (x == $signed(MIN_NEG)) return MAX_POS;
    else if (x < 0)            return $unsigned(negx);
    else                       return $unsigned(x);
  endfunction

  // Reflect the positive-half sigmoid for negative inputs: s(-x) = 1 - s(x).
  function automatic logic [DATA_WIDTH-1:0] sign_fix(input logic neg,
                                                     input logic [DATA_WIDTH-1:0] y);
    return neg ? (ONE - y) : y;
  endfunction

  logic                         stall;
  logic                         adv;

  logic                         vld_p1_q, vld_p2_q, vld_p3_q;
  logic [DATA_WIDTH-1:0]        mag_p1_q;
  seg_e                         seg_p1_q;
  logic                         neg_p1_q, neg_p2_q;
  act_sel_e                     sel_p1_q, sel_p2_q;
  logic signed [DATA_WIDTH-1:0] x_p1_q, x_p2_q;
  logic [DATA_WIDTH-1:0]        y_p2_q;
  logic [DATA_WIDTH-1:0]        data_out_q;

  logic signed [DATA_WIDTH-1:0] x_p0;
  logic [DATA_WIDTH-1:0]        mag_p0;
  logic [DATA_WIDTH-1:0]        y_p1;
  logic [DATA_WIDTH-1:0]        result_d;

  assign stall     = vld_p3_q & ~ready_in;
  assign adv       = ~stall;
  assign ready_out = adv;
  assign valid_out = vld_p3_q;
  assign data_out  = data_out_q;

  assign x_p0   = $signed(data_in);
  assign mag_p0 = sat_abs(x_p0);

  // Valid bits: the only reset state besides the output word.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (adv) begin
      vld_p1_q <= valid_in;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
    end
  end

  // ---- S1: magnitude, sign, select, raw x, segment index ----
  always_ff @(posedge clk_in) begin
    if (adv) begin
      mag_p1_q <= mag_p0;
      seg_p1_q <= plan_seg(mag_p0);
      neg_p1_q <= x_p0[DATA_WIDTH-1];
      sel_p1_q <= act_sel_e'(act_sel_in);
      x_p1_q   <= x_p0;
    end
  end

  plan_sigmoid_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .mag_i(mag_p1_q),
    .seg_i(seg_p1_q),
    .y_o  (y_p1)
  );

  // ---- S2: segment shift+add result ----
  always_ff @(posedge clk_in) begin
    if (adv) begin
      y_p2_q   <= y_p1;
      neg_p2_q <= neg_p1_q;
      sel_p2_q <= sel_p1_q;
      x_p2_q   <= x_p1_q;
    end
  end

  // Final function mux: sign-corrected sigmoid, ReLU, or pass-through.
  always_comb begin
    result_d = $unsigned(x_p2_q);
    case (sel_p2_q)
      ACT_RELU:    result_d = (x_p2_q < 0) ? '0 : $unsigned(x_p2_q);
      ACT_SIGMOID: result_d = sign_fix(neg_p2_q, y_p2_q);
      default:     result_d = $unsigned(x_p2_q);
    endcase
  end

  // ---- S3: output word, updated only for valid words so bubbles keep it ----
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_out_q <= '0;
    end else if (adv && vld_p2_q) begin
      data_out_q <= result_d;
    end
  end

endmodule

// File: tb/tb_activation_unit.sv
module tb_activation_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] data_in;
  logic [1:0]  act_sel_in;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] data_out;
  logic        valid_out;
  logic        ready_in;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  activation_unit #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .data_in   (data_in),
    .act_sel_in(act_sel_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference activation straight from the function definitions.
  function automatic logic [15:0] ref_act(input logic [15:0] xin, input logic [1:0] sel);
    int x, ax, y;
    x = $signed(xin);
    if (sel == 2'd0) return (x < 0) ? 16'h0000 : xin;
    if (sel != 2'd1) return xin;
    ax = (x < 0) ? -x : x;
    if (ax > 32767) ax = 32767;
    if (ax >= 1280)     y = 256;
    else if (ax >= 608) y = ax / 32 + 216;
    else if (ax >= 256) y = ax / 8 + 160;
    else                y = ax / 4 + 128;
    if (x < 0) y = 256 - y;
    return 16'(y);
  endfunction

  typedef struct {
    logic [15:0] d;
    int          cyc;
    int          st;
    logic [15:0] lit;
    bit          has;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          cyc = 0;
  int          stall_cnt = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data;
  logic [15:0] lit_v = '0;
  bit          has_lit = 0;

  // Scoreboard: accepts, emissions, latency, stall stability, ready.
  always @(negedge clk_in) begin
    if (rst_in) begin
      q.delete();
      prev_stall = 0;
    end else begin
      chk("ready_out", ready_out, !(valid_out && !ready_in));
      if (prev_stall) begin
        chk("stall_hold_data", data_out, prev_data);
        chk("stall_hold_valid", valid_out, 1'b1);
      end
      if (valid_out && ready_in) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk("data", data_out, e.d);
          chk("latency", cyc - e.cyc, 3 + (stall_cnt - e.st));
          if (e.has) chk("literal", data_out, e.lit);
        end
      end
      if (valid_in && ready_out)
        q.push_back('{ref_act(data_in, act_sel_in), cyc, stall_cnt, lit_v, has_lit});
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
      if (prev_stall) stall_cnt++;
    end
    cyc++;
  end

  // Present one word (called at posedge+1) and hold it until accepted.
  task automatic send(input logic [15:0] x, input logic [1:0] sel,
                      input logic [15:0] lit, input bit has);
    int t;
    data_in = x; act_sel_in = sel; valid_in = 1'b1;
    lit_v = lit; has_lit = has;
    t = 0;
    @(negedge clk_in);
    while (!ready_out && t < 50) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= 50) chk("send_timeout", 1'b1, 1'b0);
    @(posedge clk_in); #1;
    has_lit = 0;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    @(posedge clk_in); #1;
  endtask

  logic [15:0] sig_in  [6] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0200, 16'h0600, 16'h8000};
  logic [15:0] sig_exp [6] = '{16'h0080, 16'h00C0, 16'h0040, 16'h00E0, 16'h0100, 16'h0000};
  bit          bub     [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int t;
    rst_in = 1'b1; valid_in = 1'b0; data_in = '0; act_sel_in = 2'd0; ready_in = 1'b1;

    // Pin the model with hand-computed points.
    chk("model_sig_0000", ref_act(16'h0000, 2'd1), 16'h0080);
    chk("model_sig_0100", ref_act(16'h0100, 2'd1), 16'h00C0);
    chk("model_sig_FF00", ref_act(16'hFF00, 2'd1), 16'h0040);
    chk("model_sig_0300", ref_act(16'h0300, 2'd1), 16'h00F0);
    chk("model_sig_8000", ref_act(16'h8000, 2'd1), 16'h0000);
    chk("model_relu_neg", ref_act(16'hFF00, 2'd0), 16'h0000);

    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_data_out", data_out, 16'h0000);
    chk("rst_ready_out", ready_out, 1'b1);

    // Sigmoid points back-to-back.
    for (int i = 0; i < 6; i++) send(sig_in[i], 2'd1, sig_exp[i], 1'b1);
    idle();

    // ReLU / identity, then alternating selects on the same word.
    send(16'hFF00, 2'd0, 16'h0000, 1'b1);
    send(16'h0123, 2'd0, 16'h0123, 1'b1);
    send(16'hFF00, 2'd2, 16'hFF00, 1'b1);
    send(16'hFF00, 2'd3, 16'hFF00, 1'b1);
    for (int i = 0; i < 6; i++) send(16'hFE80, 2'(i % 3), 16'h0, 1'b0);
    idle(); repeat (4) idle();

    // Backpressure: 6 words, 4-cycle stall once output is valid.
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'(16'h0040 * i + 16'h0010), 2'(i % 3), 16'h0, 1'b0);
        valid_in = 1'b0;
      end
      begin
        t = 0;
        while (!valid_out && t < 20) begin
          @(posedge clk_in); #1;
          t++;
        end
        if (t >= 20) chk("bp_wait_valid", 1'b1, 1'b0);
        ready_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1 ready_in = 1'b1;
      end
    join
    repeat (6) idle();

    // Bubbles: valid pattern 1,0,1,1,0.
    for (int i = 0; i < 5; i++) begin
      if (bub[i]) send(16'(16'h0300 + i), 2'd1, 16'h0, 1'b0);
      else idle();
    end
    repeat (4) idle();

    // Reset with three words in flight.
    send(16'h0100, 2'd1, 16'h0, 1'b0);
    send(16'h0200, 2'd1, 16'h0, 1'b0);
    send(16'h0300, 2'd1, 16'h0, 1'b0);
    valid_in = 1'b0; rst_in = 1'b1;
    @(posedge clk_in); #1 rst_in = 1'b0;
    chk("midrst_valid_out", valid_out, 1'b0);
    chk("midrst_data_out", data_out, 16'h0000);
    idle();
    chk("midrst_valid_out2", valid_out, 1'b0);
    send(16'h0100, 2'd1, 16'h00C0, 1'b1);
    repeat (4) idle();

    // Full sigmoid sweep.
    for (int i = 0; i < 65536; i++) send(16'(i), 2'd1, 16'h0, 1'b0);
    valid_in = 1'b0;

    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk_in); #1;
      t++;
    end
    chk("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
